// File: rtl/alu_pkg.sv
// ALU control codes, R-type funct codes and ID alu_op codes shared by the
// ID/EX stage, its control decoder and the bench.
package alu_pkg;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADDU = 4'b0010;
  localparam logic [3:0] ALU_XOR  = 4'b0011;
  localparam logic [3:0] ALU_NOR  = 4'b0100;
  localparam logic [3:0] ALU_SUBU = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_SLL  = 4'b1000;
  localparam logic [3:0] ALU_SRL  = 4'b1001;
  localparam logic [3:0] ALU_ADDS = 4'b1011;
  localparam logic [3:0] ALU_SUBS = 4'b1100;
  localparam logic [3:0] ALU_BAD  = 4'b1111;

  localparam logic [5:0] FUNCT_SLL  = 6'h00;
  localparam logic [5:0] FUNCT_SRL  = 6'h02;
  localparam logic [5:0] FUNCT_ADD  = 6'h20;
  localparam logic [5:0] FUNCT_ADDU = 6'h21;
  localparam logic [5:0] FUNCT_SUB  = 6'h22;
  localparam logic [5:0] FUNCT_SUBU = 6'h23;
  localparam logic [5:0] FUNCT_AND  = 6'h24;
  localparam logic [5:0] FUNCT_OR   = 6'h25;
  localparam logic [5:0] FUNCT_XOR  = 6'h26;
  localparam logic [5:0] FUNCT_NOR  = 6'h27;
  localparam logic [5:0] FUNCT_SLT  = 6'h2A;

  typedef enum logic [2:0] {
    ALUOP_ADDU  = 3'b000,
    ALUOP_SUBU  = 3'b001,
    ALUOP_RTYPE = 3'b010,
    ALUOP_AND   = 3'b011,
    ALUOP_OR    = 3'b100,
    ALUOP_XOR   = 3'b101,
    ALUOP_SLT   = 3'b110,
    ALUOP_ADDS  = 3'b111
  } alu_op_e;

  // Shifts take the shifted value from rt and the amount from shamt.
  function automatic logic is_shift(input logic [3:0] ctrl);
    return (ctrl == ALU_SLL) || (ctrl == ALU_SRL);
  endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// ID/EX stage bus: decoded ID fields, stall/flush, forwarding sources and EX outputs.
interface id_ex_stage_if #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned REG_ADDR_W = 5
);
  logic                  id_valid;
  logic [2:0]            id_alu_op;
  logic [5:0]            id_funct;
  logic [4:0]            id_shamt;
  logic [DATA_W-1:0]     id_rs_data;
  logic [DATA_W-1:0]     id_rt_data;
  logic [DATA_W-1:0]     id_imm;
  logic                  id_alu_src;
  logic [REG_ADDR_W-1:0] id_rs;
  logic [REG_ADDR_W-1:0] id_rt;
  logic [REG_ADDR_W-1:0] id_rd;
  logic                  id_reg_dst;
  logic                  id_reg_write;
  logic                  id_mem_read;
  logic                  id_mem_write;
  logic                  id_mem_to_reg;
  logic                  stall;
  logic                  flush;
  logic                  exm_reg_write;
  logic [REG_ADDR_W-1:0] exm_rd;
  logic [DATA_W-1:0]     exm_result;
  logic                  wb_reg_write;
  logic [REG_ADDR_W-1:0] wb_rd;
  logic [DATA_W-1:0]     wb_result;

  logic                  ex_valid;
  logic [3:0]            alu_control;
  logic [DATA_W-1:0]     operand0;
  logic [DATA_W-1:0]     operand1;
  logic [REG_ADDR_W-1:0] ex_dest;
  logic                  ex_reg_write;
  logic                  ex_mem_read;
  logic                  ex_mem_write;
  logic                  ex_mem_to_reg;
  logic [DATA_W-1:0]     ex_store_data;
  logic                  illegal_op;
  logic                  hazard_stall;

  modport master (
    output id_valid, id_alu_op, id_funct, id_shamt, id_rs_data, id_rt_data, id_imm,
           id_alu_src, id_rs, id_rt, id_rd, id_reg_dst, id_reg_write, id_mem_read,
           id_mem_write, id_mem_to_reg, stall, flush, exm_reg_write, exm_rd, exm_result,
           wb_reg_write, wb_rd, wb_result,
    input  ex_valid, alu_control, operand0, operand1, ex_dest, ex_reg_write, ex_mem_read,
           ex_mem_write, ex_mem_to_reg, ex_store_data, illegal_op, hazard_stall
  );

  modport slave (
    input  id_valid, id_alu_op, id_funct, id_shamt, id_rs_data, id_rt_data, id_imm,
           id_alu_src, id_rs, id_rt, id_rd, id_reg_dst, id_reg_write, id_mem_read,
           id_mem_write, id_mem_to_reg, stall, flush, exm_reg_write, exm_rd, exm_result,
           wb_reg_write, wb_rd, wb_result,
    output ex_valid, alu_control, operand0, operand1, ex_dest, ex_reg_write, ex_mem_read,
           ex_mem_write, ex_mem_to_reg, ex_store_data, illegal_op, hazard_stall
  );

endinterface

// File: rtl/alu_control_decode.sv
// Combinational alu_op/funct to 4-bit ALU control decode; flags undecodable R-type funct.
module alu_control_decode
  import alu_pkg::*;
(
  input  logic [2:0] i_alu_op,
  input  logic [5:0] i_funct,
  output logic [3:0] o_alu_control,
  output logic       o_illegal
);

  always_comb begin
    o_alu_control = ALU_ADDU;
    o_illegal     = 1'b0;
    case (i_alu_op)
      ALUOP_ADDU: o_alu_control = ALU_ADDU;
      ALUOP_SUBU: o_alu_control = ALU_SUBU;
      ALUOP_AND:  o_alu_control = ALU_AND;
      ALUOP_OR:   o_alu_control = ALU_OR;
      ALUOP_XOR:  o_alu_control = ALU_XOR;
      ALUOP_SLT:  o_alu_control = ALU_SLT;
      ALUOP_ADDS: o_alu_control = ALU_ADDS;
      ALUOP_RTYPE: begin
        case (i_funct)
          FUNCT_ADD:  o_alu_control = ALU_ADDS;
          FUNCT_ADDU: o_alu_control = ALU_ADDU;
          FUNCT_SUB:  o_alu_control = ALU_SUBS;
          FUNCT_SUBU: o_alu_control = ALU_SUBU;
          FUNCT_AND:  o_alu_control = ALU_AND;
          FUNCT_OR:   o_alu_control = ALU_OR;
          FUNCT_XOR:  o_alu_control = ALU_XOR;
          FUNCT_NOR:  o_alu_control = ALU_NOR;
          FUNCT_SLT:  o_alu_control = ALU_SLT;
          FUNCT_SLL:  o_alu_control = ALU_SLL;
          FUNCT_SRL:  o_alu_control = ALU_SRL;
          default: begin
            o_alu_control = ALU_BAD;
            o_illegal     = 1'b1;
          end
        endcase
      end
      default: o_alu_control = ALU_ADDU;
    endcase
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with ALU control decode, operand forwarding and
// load-use hazard detection.
module id_ex_stage
  import alu_pkg::*;
#(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned REG_ADDR_W = 5
) (
  input logic          clk,
  input logic          rst_n,
  id_ex_stage_if.slave bus
);

  logic                  r_valid;
  logic [3:0]            r_alu_control;
  logic                  r_illegal;
  logic                  r_reg_write;
  logic                  r_mem_read;
  logic                  r_mem_write;
  logic                  r_mem_to_reg;
  logic                  r_alu_src;
  logic [REG_ADDR_W-1:0] r_dest;
  logic [REG_ADDR_W-1:0] r_rs;
  logic [REG_ADDR_W-1:0] r_rt;
  logic [4:0]            r_shamt;
  logic [DATA_W-1:0]     r_rs_data;
  logic [DATA_W-1:0]     r_rt_data;
  logic [DATA_W-1:0]     r_imm;

  logic [3:0]            w_dec_ctrl;
  logic                  w_dec_illegal;
  logic                  w_hazard;
  logic                  w_bubble;
  logic                  w_load;
  logic [REG_ADDR_W-1:0] w_dest_sel;
  logic [DATA_W-1:0]     w_rs_fwd;
  logic [DATA_W-1:0]     w_rt_fwd;

  alu_control_decode u_decode (
    .i_alu_op      (bus.id_alu_op),
    .i_funct       (bus.id_funct),
    .o_alu_control (w_dec_ctrl),
    .o_illegal     (w_dec_illegal)
  );

  // Load in EX whose destination is read by the instruction in ID.
  assign w_hazard = r_valid & r_mem_read & (r_dest != '0) & bus.id_valid &
                    ((r_dest == bus.id_rs) | ((r_dest == bus.id_rt) & ~bus.id_alu_src));

  assign w_bubble   = bus.flush | (~bus.stall & (w_hazard | ~bus.id_valid));
  assign w_load     = ~bus.flush & ~bus.stall & ~w_hazard & bus.id_valid;
  assign w_dest_sel = bus.id_reg_dst ? bus.id_rd : bus.id_rt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid       <= 1'b0;
      r_alu_control <= 4'b0000;
      r_illegal     <= 1'b0;
      r_reg_write   <= 1'b0;
      r_mem_read    <= 1'b0;
      r_mem_write   <= 1'b0;
      r_mem_to_reg  <= 1'b0;
      r_alu_src     <= 1'b0;
      r_dest        <= '0;
      r_rs          <= '0;
      r_rt          <= '0;
      r_shamt       <= '0;
      r_rs_data     <= '0;
      r_rt_data     <= '0;
      r_imm         <= '0;
    end else if (w_bubble) begin
      r_valid       <= 1'b0;
      r_alu_control <= ALU_ADDU;
      r_illegal     <= 1'b0;
      r_reg_write   <= 1'b0;
      r_mem_read    <= 1'b0;
      r_mem_write   <= 1'b0;
      r_mem_to_reg  <= 1'b0;
      r_alu_src     <= 1'b0;
      r_dest        <= '0;
      r_rs          <= '0;
      r_rt          <= '0;
      r_shamt       <= '0;
      r_rs_data     <= '0;
      r_rt_data     <= '0;
      r_imm         <= '0;
    end else if (w_load) begin
      r_valid       <= 1'b1;
      r_alu_control <= w_dec_ctrl;
      r_illegal     <= w_dec_illegal;
      r_reg_write   <= bus.id_reg_write & ~w_dec_illegal;
      r_mem_read    <= bus.id_mem_read;
      r_mem_write   <= bus.id_mem_write;
      r_mem_to_reg  <= bus.id_mem_to_reg;
      r_alu_src     <= bus.id_alu_src;
      r_dest        <= w_dest_sel;
      r_rs          <= bus.id_rs;
      r_rt          <= bus.id_rt;
      r_shamt       <= bus.id_shamt;
      r_rs_data     <= bus.id_rs_data;
      r_rt_data     <= bus.id_rt_data;
      r_imm         <= bus.id_imm;
    end
  end

  // Register 0 is hard-wired; EX/MEM takes precedence over MEM/WB.
  function automatic logic [DATA_W-1:0] fwd(
    input logic [REG_ADDR_W-1:0] idx,
    input logic [DATA_W-1:0]     latched,
    input logic                  exm_we,
    input logic [REG_ADDR_W-1:0] exm_idx,
    input logic [DATA_W-1:0]     exm_val,
    input logic                  wb_we,
    input logic [REG_ADDR_W-1:0] wb_idx,
    input logic [DATA_W-1:0]     wb_val
  );
    if (idx == '0)                        return '0;
    else if (exm_we && (exm_idx == idx)) return exm_val;
    else if (wb_we && (wb_idx == idx))   return wb_val;
    else                                 return latched;
  endfunction

  assign w_rs_fwd = fwd(r_rs, r_rs_data, bus.exm_reg_write, bus.exm_rd, bus.exm_result,
                        bus.wb_reg_write, bus.wb_rd, bus.wb_result);
  assign w_rt_fwd = fwd(r_rt, r_rt_data, bus.exm_reg_write, bus.exm_rd, bus.exm_result,
                        bus.wb_reg_write, bus.wb_rd, bus.wb_result);

  always_comb begin
    bus.operand0      = '0;
    bus.operand1      = '0;
    bus.ex_store_data = '0;
    if (r_valid) begin
      bus.ex_store_data = w_rt_fwd;
      if (is_shift(r_alu_control)) begin
        bus.operand0 = w_rt_fwd;
        bus.operand1 = {{(DATA_W-5){1'b0}}, r_shamt};
      end else begin
        bus.operand0 = w_rs_fwd;
        bus.operand1 = r_alu_src ? r_imm : w_rt_fwd;
      end
    end
  end

  assign bus.ex_valid      = r_valid;
  assign bus.alu_control   = r_alu_control;
  assign bus.illegal_op    = r_illegal;
  assign bus.ex_dest       = r_dest;
  assign bus.ex_reg_write  = r_reg_write;
  assign bus.ex_mem_read   = r_mem_read;
  assign bus.ex_mem_write  = r_mem_write;
  assign bus.ex_mem_to_reg = r_mem_to_reg;
  assign bus.hazard_stall  = w_hazard;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed and randomized bench for id_ex_stage against a behavioural model of
// the stage contents and the forwarding rules.
module tb_id_ex_stage;
  import alu_pkg::*;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  id_ex_stage_if #(.DATA_W(DW), .REG_ADDR_W(AW)) bus ();

  id_ex_stage #(.DATA_W(DW), .REG_ADDR_W(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic        valid;
    logic [3:0]  ctrl;
    logic        illegal, rw, mr, mw, m2r, alu_src;
    logic [4:0]  dest, rs, rt, shamt;
    logic [31:0] rsd, rtd, imm;
  } ex_t;

  ex_t m;
  int n_checks = 0;
  int n_errors = 0;
  logic [5:0] legal_funct [11] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26,
                                   6'h27, 6'h2A, 6'h00, 6'h02};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic ex_t empty_stage(input logic [3:0] ctrl);
    ex_t e = '{default: '0};
    e.ctrl = ctrl;
    return e;
  endfunction

  // Returns {illegal, ctrl} from the instruction-set tables.
  function automatic logic [4:0] ref_decode(input logic [2:0] op, input logic [5:0] fn);
    case (op)
      3'd0: return {1'b0, 4'b0010};
      3'd1: return {1'b0, 4'b0110};
      3'd3: return {1'b0, 4'b0000};
      3'd4: return {1'b0, 4'b0001};
      3'd5: return {1'b0, 4'b0011};
      3'd6: return {1'b0, 4'b0111};
      3'd7: return {1'b0, 4'b1011};
      default: begin
        case (fn)
          6'h20: return {1'b0, 4'b1011};
          6'h21: return {1'b0, 4'b0010};
          6'h22: return {1'b0, 4'b1100};
          6'h23: return {1'b0, 4'b0110};
          6'h24: return {1'b0, 4'b0000};
          6'h25: return {1'b0, 4'b0001};
          6'h26: return {1'b0, 4'b0011};
          6'h27: return {1'b0, 4'b0100};
          6'h2A: return {1'b0, 4'b0111};
          6'h00: return {1'b0, 4'b1000};
          6'h02: return {1'b0, 4'b1001};
          default: return {1'b1, 4'b1111};
        endcase
      end
    endcase
  endfunction

  function automatic logic ref_hazard();
    return m.valid && m.mr && (m.dest != 0) && bus.id_valid &&
           ((m.dest == bus.id_rs) || ((m.dest == bus.id_rt) && !bus.id_alu_src));
  endfunction

  function automatic logic [31:0] ref_fwd(input logic [4:0] idx, input logic [31:0] latched);
    if (idx == 0) return 32'h0;
    if (bus.exm_reg_write && bus.exm_rd == idx) return bus.exm_result;
    if (bus.wb_reg_write && bus.wb_rd == idx) return bus.wb_result;
    return latched;
  endfunction

  task automatic model_edge();
    logic [4:0] d;
    if (!rst_n) m = empty_stage(4'b0000);
    else if (bus.flush) m = empty_stage(4'b0010);
    else if (bus.stall) m = m;
    else if (ref_hazard() || !bus.id_valid) m = empty_stage(4'b0010);
    else begin
      d         = ref_decode(bus.id_alu_op, bus.id_funct);
      m.valid   = 1'b1;
      m.ctrl    = d[3:0];
      m.illegal = d[4];
      m.rw      = bus.id_reg_write && !d[4];
      m.mr      = bus.id_mem_read;
      m.mw      = bus.id_mem_write;
      m.m2r     = bus.id_mem_to_reg;
      m.alu_src = bus.id_alu_src;
      m.dest    = bus.id_reg_dst ? bus.id_rd : bus.id_rt;
      m.rs      = bus.id_rs;
      m.rt      = bus.id_rt;
      m.shamt   = bus.id_shamt;
      m.rsd     = bus.id_rs_data;
      m.rtd     = bus.id_rt_data;
      m.imm     = bus.id_imm;
    end
  endtask

  task automatic check_all();
    logic [31:0] e0, e1, es;
    logic shift;
    shift = (m.ctrl == 4'b1000) || (m.ctrl == 4'b1001);
    e0 = 0; e1 = 0; es = 0;
    if (m.valid) begin
      es = ref_fwd(m.rt, m.rtd);
      e0 = shift ? ref_fwd(m.rt, m.rtd) : ref_fwd(m.rs, m.rsd);
      e1 = shift ? {27'b0, m.shamt} : (m.alu_src ? m.imm : ref_fwd(m.rt, m.rtd));
    end
    check("ex_valid", 32'(bus.ex_valid), 32'(m.valid));
    check("alu_control", 32'(bus.alu_control), 32'(m.ctrl));
    check("illegal_op", 32'(bus.illegal_op), 32'(m.illegal));
    check("ex_dest", 32'(bus.ex_dest), 32'(m.dest));
    check("ex_reg_write", 32'(bus.ex_reg_write), 32'(m.rw));
    check("ex_mem_read", 32'(bus.ex_mem_read), 32'(m.mr));
    check("ex_mem_write", 32'(bus.ex_mem_write), 32'(m.mw));
    check("ex_mem_to_reg", 32'(bus.ex_mem_to_reg), 32'(m.m2r));
    check("operand0", bus.operand0, e0);
    check("operand1", bus.operand1, e1);
    check("store_data", bus.ex_store_data, es);
    check("hazard_stall", 32'(bus.hazard_stall), 32'(ref_hazard()));
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #2;
    check_all();
  endtask

  task automatic clear_inputs();
    bus.id_valid = 0; bus.id_alu_op = 0; bus.id_funct = 0; bus.id_shamt = 0;
    bus.id_rs_data = 0; bus.id_rt_data = 0; bus.id_imm = 0; bus.id_alu_src = 0;
    bus.id_rs = 0; bus.id_rt = 0; bus.id_rd = 0; bus.id_reg_dst = 0;
    bus.id_reg_write = 0; bus.id_mem_read = 0; bus.id_mem_write = 0; bus.id_mem_to_reg = 0;
    bus.stall = 0; bus.flush = 0;
    bus.exm_reg_write = 0; bus.exm_rd = 0; bus.exm_result = 0;
    bus.wb_reg_write = 0; bus.wb_rd = 0; bus.wb_result = 0;
  endtask

  task automatic set_instr(input logic [2:0] op, input logic [5:0] fn, input logic [4:0] rs,
                           input logic [31:0] rsd, input logic [4:0] rt, input logic [31:0] rtd);
    bus.id_valid = 1; bus.id_alu_op = op; bus.id_funct = fn;
    bus.id_rs = rs; bus.id_rs_data = rsd; bus.id_rt = rt; bus.id_rt_data = rtd;
    bus.id_reg_write = 1; bus.id_reg_dst = 1; bus.id_rd = 5'd9;
    bus.id_alu_src = 0; bus.id_mem_read = 0; bus.id_mem_write = 0; bus.id_mem_to_reg = 0;
  endtask

  task automatic randomize_inputs();
    bus.id_valid      = ($urandom_range(0, 7) != 0);
    bus.id_alu_op     = 3'($urandom_range(0, 7));
    bus.id_funct      = ($urandom_range(0, 7) == 0) ? 6'($urandom_range(0, 63))
                                                    : legal_funct[$urandom_range(0, 10)];
    bus.id_shamt      = 5'($urandom_range(0, 31));
    bus.id_rs_data    = $urandom;
    bus.id_rt_data    = $urandom;
    bus.id_imm        = $urandom;
    bus.id_alu_src    = 1'($urandom_range(0, 1));
    bus.id_rs         = 5'($urandom_range(0, 7));
    bus.id_rt         = 5'($urandom_range(0, 7));
    bus.id_rd         = 5'($urandom_range(0, 7));
    bus.id_reg_dst    = 1'($urandom_range(0, 1));
    bus.id_reg_write  = 1'($urandom_range(0, 1));
    bus.id_mem_read   = ($urandom_range(0, 2) == 0);
    bus.id_mem_write  = 1'($urandom_range(0, 1));
    bus.id_mem_to_reg = 1'($urandom_range(0, 1));
    bus.stall         = ($urandom_range(0, 7) == 0);
    bus.flush         = ($urandom_range(0, 15) == 0);
    bus.exm_reg_write = 1'($urandom_range(0, 1));
    bus.exm_rd        = 5'($urandom_range(0, 7));
    bus.exm_result    = $urandom;
    bus.wb_reg_write  = 1'($urandom_range(0, 1));
    bus.wb_rd         = 5'($urandom_range(0, 7));
    bus.wb_result     = $urandom;
  endtask

  initial begin
    clear_inputs();
    m = empty_stage(4'b0000);
    #12;
    check_all();
    check("reset_valid", 32'(bus.ex_valid), 32'h0);
    check("reset_alu_control", 32'(bus.alu_control), 32'h0);
    rst_n = 1'b1;

    // R-type add with no forwarding matches.
    set_instr(3'b010, 6'h20, 5'd5, 32'h7, 5'd6, 32'hFFFF_FFFF);
    tick();
    check("radd_ctrl", 32'(bus.alu_control), 32'hB);
    check("radd_op0", bus.operand0, 32'h7);
    check("radd_op1", bus.operand1, 32'hFFFF_FFFF);

    // Forwarding priority and register 0.
    set_instr(3'b000, 6'h00, 5'd3, 32'h11, 5'd2, 32'h22);
    tick();
    bus.exm_reg_write = 1; bus.exm_rd = 5'd3; bus.exm_result = 32'hAA;
    bus.wb_reg_write = 1; bus.wb_rd = 5'd3; bus.wb_result = 32'hBB;
    #1;
    check("fwd_exm", bus.operand0, 32'hAA);
    check_all();
    bus.exm_reg_write = 0;
    #1;
    check("fwd_wb", bus.operand0, 32'hBB);
    set_instr(3'b000, 6'h00, 5'd0, 32'h55, 5'd2, 32'h22);
    bus.exm_reg_write = 1; bus.exm_rd = 5'd0;
    tick();
    check("fwd_r0", bus.operand0, 32'h0);
    clear_inputs();

    // Load-use hazard: lw to r4, then add reading r4.
    set_instr(3'b000, 6'h00, 5'd1, 32'h100, 5'd4, 32'h0);
    bus.id_alu_src = 1; bus.id_mem_read = 1; bus.id_mem_to_reg = 1; bus.id_reg_dst = 0;
    tick();
    set_instr(3'b010, 6'h20, 5'd4, 32'h1, 5'd2, 32'h2);
    #1;
    check("loaduse_hazard", 32'(bus.hazard_stall), 32'h1);
    tick();
    check("loaduse_bubble_valid", 32'(bus.ex_valid), 32'h0);
    check("loaduse_bubble_rw", 32'(bus.ex_reg_write), 32'h0);

    // Stall holds for three cycles while forwarding tracks; flush beats stall.
    set_instr(3'b101, 6'h00, 5'd2, 32'h33, 5'd3, 32'h44);
    tick();
    bus.stall = 1;
    set_instr(3'b011, 6'h00, 5'd6, 32'h66, 5'd7, 32'h77);
    for (int i = 0; i < 3; i++) begin
      bus.exm_reg_write = 1; bus.exm_rd = 5'd2; bus.exm_result = 32'h1000 + i;
      #1;
      check_all();
      tick();
      check("stall_hold_ctrl", 32'(bus.alu_control), 32'h3);
    end
    bus.flush = 1;
    tick();
    check("flush_valid", 32'(bus.ex_valid), 32'h0);
    check("flush_ctrl", 32'(bus.alu_control), 32'h2);
    clear_inputs();

    // Shift and illegal funct.
    set_instr(3'b010, 6'h00, 5'd2, 32'h9, 5'd1, 32'h1);
    bus.id_shamt = 5'd3;
    tick();
    check("sll_ctrl", 32'(bus.alu_control), 32'h8);
    check("sll_op0", bus.operand0, 32'h1);
    check("sll_op1", bus.operand1, 32'h3);
    set_instr(3'b010, 6'h3F, 5'd2, 32'h9, 5'd1, 32'h1);
    tick();
    check("bad_ctrl", 32'(bus.alu_control), 32'hF);
    check("bad_illegal", 32'(bus.illegal_op), 32'h1);
    check("bad_rw", 32'(bus.ex_reg_write), 32'h0);

    // Asynchronous reset in the middle of a stall.
    set_instr(3'b100, 6'h00, 5'd2, 32'h9, 5'd1, 32'h1);
    tick();
    bus.stall = 1;
    #2;
    rst_n = 1'b0;
    #1;
    m = empty_stage(4'b0000);
    check("async_valid", 32'(bus.ex_valid), 32'h0);
    check("async_ctrl", 32'(bus.alu_control), 32'h0);
    check("async_op0", bus.operand0, 32'h0);
    check_all();
    #1;
    rst_n = 1'b1;
    clear_inputs();
    tick();
    check("post_reset_bubble", 32'(bus.ex_valid), 32'h0);

    for (int n = 0; n < 2000; n++) begin
      randomize_inputs();
      #1;
      check_all();
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
